// File: rtl/yfcpu2.sv
`timescale 1ns/1ps
// yfcpu2: multi-cycle FETCH/DECODE/EXECUTE/STORE core; BZ/JMP enabled by YFCPU2_BRANCH_EN.
// Latency: ALU/LRI 4 cycles, BZ/JMP/undefined 3 cycles, HALT parks in EXECUTE until reset.
// Backpressure: none; imem writes are accepted every cycle, including while in reset.
module yfcpu2 #(
    parameter int IM_SIZE = 8,
    parameter int RF_SIZE = 4,
    parameter int DW      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   imem_we,
    input  logic [IM_SIZE-1:0]     imem_waddr,
    input  logic [4+3*RF_SIZE-1:0] imem_wdata,
    output logic [IM_SIZE-1:0]     pc_out,
    output logic                   halted,
    output logic                   zero
);
    localparam int IW = 4 + 3*RF_SIZE;

    localparam logic [3:0] OP_HALT = 4'd0;
    localparam logic [3:0] OP_LRI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
`ifdef YFCPU2_BRANCH_EN
    localparam logic [3:0] OP_BZ   = 4'd9;
    localparam logic [3:0] OP_JMP  = 4'd10;
`endif

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DECODE  = 2'd1,
        S_EXECUTE = 2'd2,
        S_STORE   = 2'd3
    } state_t;

    logic [IW-1:0]      imem [2**IM_SIZE];
    logic [DW-1:0]      rf_q [2**RF_SIZE];

    state_t             state_q, state_d;
    logic [IM_SIZE-1:0] pc_q, pc_d;
    logic [IW-1:0]      ir_q, ir_d;
    logic [DW-1:0]      w_q, w_d;
    logic               zero_q, zero_d;
    logic               halted_q, halted_d;
    logic               rf_we;

    logic [3:0]           op;
    logic [RF_SIZE-1:0]   ra, rb, rd;
    logic [2*RF_SIZE-1:0] imm;
    logic [DW-1:0]        opa, opb;

    assign op  = ir_q[IW-1 -: 4];
    assign ra  = ir_q[3*RF_SIZE-1 -: RF_SIZE];
    assign rb  = ir_q[2*RF_SIZE-1 -: RF_SIZE];
    assign rd  = ir_q[RF_SIZE-1:0];
    assign imm = {ra, rb};
    assign opa = rf_q[ra];
    assign opb = rf_q[rb];

    assign pc_out = pc_q;
    assign halted = halted_q;
    assign zero   = zero_q;

    // No reset on the program store: it must survive reset and be loadable during it.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        w_d      = w_q;
        zero_d   = zero_q;
        halted_d = halted_q;
        rf_we    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_d    = imem[pc_q];
                state_d = S_DECODE;
            end
            S_DECODE: begin
                pc_d     = pc_q + IM_SIZE'(1);
                halted_d = (op == OP_HALT);
                state_d  = S_EXECUTE;
            end
            S_EXECUTE: begin
                case (op)
                    OP_HALT: state_d = S_EXECUTE;
                    OP_LRI: begin
                        w_d     = DW'(imm);
                        state_d = S_STORE;
                    end
                    OP_ADD: begin
                        w_d     = opa + opb;
                        state_d = S_STORE;
                    end
                    OP_SUB: begin
                        w_d     = opa - opb;
                        state_d = S_STORE;
                    end
                    OP_OR: begin
                        w_d     = opa | opb;
                        state_d = S_STORE;
                    end
                    OP_XOR: begin
                        w_d     = opa ^ opb;
                        state_d = S_STORE;
                    end
                    OP_AND: begin
                        w_d     = opa & opb;
                        state_d = S_STORE;
                    end
`ifdef YFCPU2_BRANCH_EN
                    OP_BZ: begin
                        if (zero_q) begin
                            pc_d = IM_SIZE'(imm);
                        end
                        state_d = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_d    = IM_SIZE'(imm);
                        state_d = S_FETCH;
                    end
`endif
                    default: state_d = S_FETCH;
                endcase
            end
            S_STORE: begin
                rf_we   = 1'b1;
                zero_d  = (w_q == '0);
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            w_q      <= '0;
            zero_q   <= 1'b0;
            halted_q <= 1'b0;
            for (int i = 0; i < 2**RF_SIZE; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            w_q      <= w_d;
            zero_q   <= zero_d;
            halted_q <= halted_d;
            if (rf_we) begin
                rf_q[rd] <= w_q;
            end
        end
    end

endmodule

// File: tb/tb_yfcpu2.sv
`timescale 1ns/1ps
// Scoreboard bench for yfcpu2: an instruction-level model predicts per-instruction end cycles and state.
module tb_yfcpu2;
`ifdef YFCPU2_BRANCH_EN
    localparam bit BRANCH_EN = 1'b1;
`else
    localparam bit BRANCH_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_we = 1'b0;
    logic [7:0]  imem_waddr = 8'h00;
    logic [15:0] imem_wdata = 16'h0000;
    logic [7:0]  pc_out;
    logic        halted;
    logic        zero;

    always #5 clk = ~clk;

    yfcpu2 dut (
        .clk        (clk),
        .rst        (rst),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .pc_out     (pc_out),
        .halted     (halted),
        .zero       (zero)
    );

    typedef struct {
        int         cyc;
        logic [7:0] pc;
        logic       zero;
        logic       halted;
        bit         chk_reg;
        int         rd;
        logic [7:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_m;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    string       cur_test = "none";
    logic [15:0] mem_m [256];

    // Edges since reset release; the first edge after release is cycle 1 (the first FETCH).
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst) begin
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e_m = sb.pop_front();
                n_cmp++;
                if (pc_out !== e_m.pc || zero !== e_m.zero || halted !== e_m.halted) begin
                    n_bad++;
                    $display("FAIL %s cyc%0d state: pc_out=%h zero=%b halted=%b, expected pc_out=%h zero=%b halted=%b",
                             cur_test, cyc, pc_out, zero, halted, e_m.pc, e_m.zero, e_m.halted);
                end
                if (e_m.chk_reg) begin
                    n_cmp++;
                    if (dut.rf_q[e_m.rd] !== e_m.val) begin
                        n_bad++;
                        $display("FAIL %s cyc%0d R%0d: got %h, expected %h",
                                 cur_test, cyc, e_m.rd, dut.rf_q[e_m.rd], e_m.val);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d events pending", sb.size());
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rd);
        return {op, ra, rb, rd};
    endfunction

    task automatic imem_write(input logic [7:0] a, input logic [15:0] d);
        imem_we    = 1'b1;
        imem_waddr = a;
        imem_wdata = d;
        mem_m[a]   = d;
        @(posedge clk);
        #1;
        imem_we = 1'b0;
    endtask

    // Runs the program in mem_m from address 0 with cleared state and queues the expectations.
    task automatic model_run(input int n_max);
        logic [7:0]  pc, pcn, a, b, w;
        logic [7:0]  rf [16];
        logic        z;
        int          t;
        logic [15:0] ir;
        logic [3:0]  op, ra, rb, rd;
        exp_t        e;
        for (int i = 0; i < 16; i++) rf[i] = 8'h00;
        pc = 8'h00;
        z  = 1'b0;
        t  = 0;
        for (int k = 0; k < n_max; k++) begin
            ir  = mem_m[pc];
            op  = ir[15:12];
            ra  = ir[11:8];
            rb  = ir[7:4];
            rd  = ir[3:0];
            pcn = pc + 8'd1;
            a   = rf[ra];
            b   = rf[rb];
            e.chk_reg = 1'b0;
            e.rd      = rd;
            e.val     = 8'h00;
            e.halted  = 1'b0;
            if (op == 4'd0) begin
                e.cyc = t + 2; e.pc = pcn; e.zero = z; e.halted = 1'b1;
                sb.push_back(e);
                e.cyc = t + 7;
                sb.push_back(e);
                break;
            end
            if (op == 4'd1 || (op >= 4'd4 && op <= 4'd8)) begin
                case (op)
                    4'd1:    w = {ra, rb};
                    4'd4:    w = a + b;
                    4'd5:    w = a - b;
                    4'd6:    w = a | b;
                    4'd7:    w = a ^ b;
                    default: w = a & b;
                endcase
                rf[rd]    = w;
                z         = (w == 8'h00);
                t         = t + 4;
                e.chk_reg = 1'b1;
                e.val     = w;
            end else begin
                if (BRANCH_EN && (op == 4'd10 || (op == 4'd9 && z))) pcn = {ra, rb};
                t = t + 3;
            end
            e.cyc = t; e.pc = pcn; e.zero = z;
            sb.push_back(e);
            pc = pcn;
        end
    endtask

    task automatic drain(input int budget, output bit done);
        for (int i = 0; i < budget && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        done = (sb.size() == 0);
    endtask

    task automatic load_blank();
        for (int i = 0; i < 256; i++) imem_write(i[7:0], 16'h0000);
    endtask

    task automatic test_reset(input string tag);
        int bad;
        cur_test = tag;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (pc_out !== 8'h00 || halted !== 1'b0 || zero !== 1'b0) begin
            n_bad++;
            $display("FAIL %s outputs: pc_out=%h halted=%b zero=%b, expected 00 0 0", tag, pc_out, halted, zero);
        end
        n_cmp++;
        if (dut.ir_q !== 16'h0000 || dut.w_q !== 8'h00 || dut.state_q !== 2'd0) begin
            n_bad++;
            $display("FAIL %s core regs: ir=%h w=%h state=%0d, expected 0000 00 0", tag, dut.ir_q, dut.w_q, dut.state_q);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) if (dut.rf_q[i] !== 8'h00) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s regfile: %0d registers nonzero, expected 0", tag, bad);
        end
    endtask

    task automatic load_add_prog();
        imem_write(8'h00, ins(4'd1, 4'h2, 4'h4, 4'd1));
        imem_write(8'h01, ins(4'd1, 4'h1, 4'hB, 4'd2));
        imem_write(8'h02, ins(4'd4, 4'd1, 4'd2, 4'd3));
        imem_write(8'h03, ins(4'd0, 4'd0, 4'd0, 4'd0));
    endtask

    task automatic test_basic();
        bit done;
        cur_test = "basic_add";
        @(negedge clk); rst = 1'b0;
        load_add_prog();
        model_run(10);
        @(negedge clk); rst = 1'b1;
        drain(100, done);
        n_cmp++;
        if (!done) begin n_bad++; $display("FAIL %s timeout: %0d events left, required 0", cur_test, sb.size()); sb.delete(); end
        n_cmp++;
        if (dut.rf_q[3] !== 8'h3F || pc_out !== 8'h04 || halted !== 1'b1 || zero !== 1'b0) begin
            n_bad++;
            $display("FAIL %s final: R3=%h pc=%h halted=%b zero=%b, expected 3f 04 1 0",
                     cur_test, dut.rf_q[3], pc_out, halted, zero);
        end
    endtask

    task automatic test_sub_bz();
        bit done;
        cur_test = "sub_bz_taken";
        @(negedge clk); rst = 1'b0;
        load_add_prog();
        imem_write(8'h03, ins(4'd5, 4'd3, 4'd3, 4'd4));
        imem_write(8'h04, ins(4'd9, 4'h0, 4'h8, 4'd0));
        imem_write(8'h05, ins(4'd1, 4'hA, 4'hA, 4'd5));
        imem_write(8'h06, ins(4'd1, 4'h0, 4'h1, 4'd6));
        imem_write(8'h07, ins(4'd0, 4'd0, 4'd0, 4'd0));
        imem_write(8'h08, ins(4'd0, 4'd0, 4'd0, 4'd0));
        model_run(20);
        @(negedge clk); rst = 1'b1;
        drain(100, done);
        n_cmp++;
        if (!done) begin n_bad++; $display("FAIL %s timeout: %0d events left, required 0", cur_test, sb.size()); sb.delete(); end
    endtask

    task automatic test_bz_not_taken();
        bit done;
        cur_test = "bz_not_taken";
        @(negedge clk); rst = 1'b0;
        imem_write(8'h00, ins(4'd1, 4'h0, 4'h1, 4'd1));
        imem_write(8'h01, ins(4'd9, 4'h2, 4'h0, 4'd0));
        imem_write(8'h02, ins(4'd1, 4'h0, 4'h2, 4'd2));
        imem_write(8'h03, ins(4'd0, 4'd0, 4'd0, 4'd0));
        imem_write(8'h20, ins(4'd1, 4'h3, 4'h3, 4'd3));
        imem_write(8'h21, ins(4'd0, 4'd0, 4'd0, 4'd0));
        model_run(20);
        @(negedge clk); rst = 1'b1;
        drain(100, done);
        n_cmp++;
        if (!done) begin n_bad++; $display("FAIL %s timeout: %0d events left, required 0", cur_test, sb.size()); sb.delete(); end
    endtask

    task automatic test_jmp_undef();
        bit done;
        cur_test = "jmp_undef";
        @(negedge clk); rst = 1'b0;
        imem_write(8'h00, ins(4'd10, 4'h1, 4'h0, 4'd0));
        imem_write(8'h01, ins(4'd1, 4'h5, 4'h5, 4'd6));
        imem_write(8'h02, ins(4'd2, 4'd1, 4'd1, 4'd1));
        imem_write(8'h03, ins(4'd15, 4'd0, 4'd0, 4'd7));
        imem_write(8'h04, ins(4'd0, 4'd0, 4'd0, 4'd0));
        imem_write(8'h10, ins(4'd1, 4'h7, 4'h7, 4'd6));
        imem_write(8'h11, ins(4'd0, 4'd0, 4'd0, 4'd0));
        model_run(20);
        @(negedge clk); rst = 1'b1;
        drain(100, done);
        n_cmp++;
        if (!done) begin n_bad++; $display("FAIL %s timeout: %0d events left, required 0", cur_test, sb.size()); sb.delete(); end
    endtask

    task automatic test_alu();
        bit done;
        cur_test = "alu_ops";
        @(negedge clk); rst = 1'b0;
        imem_write(8'h00, ins(4'd1, 4'hF, 4'h0, 4'd1));
        imem_write(8'h01, ins(4'd1, 4'h3, 4'hC, 4'd2));
        imem_write(8'h02, ins(4'd6, 4'd1, 4'd2, 4'd3));
        imem_write(8'h03, ins(4'd7, 4'd1, 4'd2, 4'd4));
        imem_write(8'h04, ins(4'd8, 4'd1, 4'd2, 4'd5));
        imem_write(8'h05, ins(4'd5, 4'd2, 4'd1, 4'd6));
        imem_write(8'h06, ins(4'd4, 4'd1, 4'd1, 4'd7));
        imem_write(8'h07, ins(4'd7, 4'd1, 4'd1, 4'd8));
        imem_write(8'h08, ins(4'd3, 4'd1, 4'd1, 4'd9));
        imem_write(8'h09, ins(4'd4, 4'd3, 4'd3, 4'd10));
        imem_write(8'h0A, ins(4'd0, 4'd0, 4'd0, 4'd0));
        model_run(20);
        @(negedge clk); rst = 1'b1;
        drain(150, done);
        n_cmp++;
        if (!done) begin n_bad++; $display("FAIL %s timeout: %0d events left, required 0", cur_test, sb.size()); sb.delete(); end
    endtask

    task automatic test_imem_collision();
        bit done;
        cur_test = "imem_same_edge";
        @(negedge clk); rst = 1'b0;
        imem_write(8'h00, ins(4'd1, 4'h0, 4'h1, 4'd1));
        imem_write(8'h01, ins(4'd1, 4'h1, 4'h1, 4'd2));
        imem_write(8'h02, ins(4'd0, 4'd0, 4'd0, 4'd0));
        model_run(10);
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 20 && cyc != 4; i++) @(negedge clk);
        // Write lands on edge 5, the same edge that fetches address 1.
        imem_we    = 1'b1;
        imem_waddr = 8'h01;
        imem_wdata = ins(4'd1, 4'h9, 4'h9, 4'd2);
        @(posedge clk);
        #1;
        imem_we  = 1'b0;
        mem_m[1] = ins(4'd1, 4'h9, 4'h9, 4'd2);
        drain(100, done);
        n_cmp++;
        if (!done) begin n_bad++; $display("FAIL %s timeout: %0d events left, required 0", cur_test, sb.size()); sb.delete(); end
        cur_test = "imem_new_word";
        @(negedge clk); rst = 1'b0;
        model_run(10);
        @(negedge clk); rst = 1'b1;
        drain(100, done);
        n_cmp++;
        if (!done) begin n_bad++; $display("FAIL %s timeout: %0d events left, required 0", cur_test, sb.size()); sb.delete(); end
    endtask

    task automatic test_wrap();
        bit done;
        logic [7:0] a;
        cur_test = "pc_wrap";
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            a = i[7:0];
            imem_write(a, ins(4'd1, a[7:4], a[3:0], a[3:0]));
        end
        model_run(260);
        @(negedge clk); rst = 1'b1;
        drain(1200, done);
        n_cmp++;
        if (!done) begin n_bad++; $display("FAIL %s timeout: %0d events left, required 0", cur_test, sb.size()); sb.delete(); end
    endtask

    task automatic test_reset_mid();
        bit done;
        cur_test = "reset_in_store";
        @(negedge clk); rst = 1'b0;
        load_add_prog();
        model_run(2);
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 30 && cyc != 11; i++) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (pc_out !== 8'h00 || dut.rf_q[3] !== 8'h00 || dut.rf_q[1] !== 8'h00 || zero !== 1'b0 || halted !== 1'b0) begin
            n_bad++;
            $display("FAIL %s immediate: pc=%h R3=%h R1=%h zero=%b halted=%b, expected 00 00 00 0 0",
                     cur_test, pc_out, dut.rf_q[3], dut.rf_q[1], zero, halted);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (pc_out !== 8'h00 || dut.state_q !== 2'd0) begin
            n_bad++;
            $display("FAIL %s held: pc=%h state=%0d, expected 00 0", cur_test, pc_out, dut.state_q);
        end
        cur_test = "restart_after_reset";
        model_run(10);
        @(negedge clk); rst = 1'b1;
        drain(100, done);
        n_cmp++;
        if (!done) begin n_bad++; $display("FAIL %s timeout: %0d events left, required 0", cur_test, sb.size()); sb.delete(); end
    endtask

    initial begin
        test_reset("reset_initial");
        load_blank();
        test_basic();
        test_reset("reset_from_halt");
        test_sub_bz();
        test_bz_not_taken();
        test_jmp_undef();
        test_alu();
        test_imem_collision();
        test_wrap();
        test_reset("reset_while_running");
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
